// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the core, DMA and memory-side signals of the data-memory arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold *_req until *_done; stall_core tells the core to wait.
interface dmem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    // core load/store port
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [2:0]    c_funct3;
    logic          c_done;
    logic [DW-1:0] c_rdata;
    // DMA / program-loader port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_funct3;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    // single-port data memory
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
    // core pipeline hold
    logic          stall_core;

    // requesters and memory model side
    modport master (
        output c_req, c_we, c_addr, c_wdata, c_funct3,
        output d_req, d_we, d_addr, d_wdata, d_funct3,
        output mem_rdata,
        input  c_done, c_rdata, d_done, d_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, mem_funct3,
        input  stall_core
    );

    // arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_funct3,
        input  d_req, d_we, d_addr, d_wdata, d_funct3,
        input  mem_rdata,
        output c_done, c_rdata, d_done, d_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, mem_funct3,
        output stall_core
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core (C) and DMA (D); build option DMEM_ARB_CORE_PRIO_EN.
// Latency: grant cycle to done pulse = MEM_LAT+1 cycles; one access per MEM_LAT+2 cycles.
// Backpressure: requests are held until done; the loser waits in IDLE arbitration, core sees stall_core.
module dmem_arbiter #(
    parameter int MEM_LAT = 1,   // 1..15 (cnt is 4 bits)
    parameter int AW      = 64,
    parameter int DW      = 64
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          own_q, own_d;          // 0 = core, 1 = DMA
    logic          we_q, we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]    mem_funct3_q, mem_funct3_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;
    logic          c_done_q, c_done_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
`ifndef DMEM_ARB_CORE_PRIO_EN
    logic          rr_ptr_q, rr_ptr_d;    // 0 = core favoured on a tie
`endif
    logic          pick_dma;

    // Next-state, grant and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        own_d        = own_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_funct3_d = mem_funct3_q;
        mem_we_d     = mem_we_q;
        mem_re_d     = mem_re_q;
        c_done_d     = 1'b0;
        d_done_d     = 1'b0;
        c_rdata_d    = c_rdata_q;
        d_rdata_d    = d_rdata_q;
`ifdef DMEM_ARB_CORE_PRIO_EN
        // core always wins a tie; DMA gets the first IDLE cycle the core leaves free
        pick_dma     = ~bus.c_req;
`else
        rr_ptr_d     = rr_ptr_q;
        pick_dma     = (bus.c_req & bus.d_req) ? rr_ptr_q : bus.d_req;
`endif

        case (state_q)
            IDLE: begin
                if (bus.c_req | bus.d_req) begin
                    own_d        = pick_dma;
                    we_d         = pick_dma ? bus.d_we     : bus.c_we;
                    mem_addr_d   = pick_dma ? bus.d_addr   : bus.c_addr;
                    mem_wdata_d  = pick_dma ? bus.d_wdata  : bus.c_wdata;
                    mem_funct3_d = pick_dma ? bus.d_funct3 : bus.c_funct3;
                    // enables become visible in the first ACCESS cycle
                    mem_we_d     = pick_dma ? bus.d_we     : bus.c_we;
                    mem_re_d     = pick_dma ? ~bus.d_we    : ~bus.c_we;
                    cnt_d        = 4'(MEM_LAT - 1);
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                // a store writes only in the first ACCESS cycle
                mem_we_d = 1'b0;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_re_d = 1'b0;
                    if (!we_q) begin
                        if (own_q) d_rdata_d = bus.mem_rdata;
                        else       c_rdata_d = bus.mem_rdata;
                    end
                    if (own_q) d_done_d = 1'b1;
                    else       c_done_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
`ifndef DMEM_ARB_CORE_PRIO_EN
                // favour the other requester next time
                rr_ptr_d = ~own_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            own_q        <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_funct3_q <= 3'd0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            c_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            c_rdata_q    <= '0;
            d_rdata_q    <= '0;
`ifndef DMEM_ARB_CORE_PRIO_EN
            rr_ptr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            own_q        <= own_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_funct3_q <= mem_funct3_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            c_done_q     <= c_done_d;
            d_done_q     <= d_done_d;
            c_rdata_q    <= c_rdata_d;
            d_rdata_q    <= d_rdata_d;
`ifndef DMEM_ARB_CORE_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign bus.c_done     = c_done_q;
    assign bus.d_done     = d_done_q;
    assign bus.c_rdata    = c_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_funct3 = mem_funct3_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;
    // core must hold its pipeline until its own done pulse
    assign bus.stall_core = bus.c_req & ~c_done_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core's load/store port (C) and a DMA/program-loader port (D).
- Latches the winner's request and drives the memory for a fixed number of cycles.
- Returns read data with a one-cycle done pulse.
- Asserts a stall to the core while its access is pending. Sits between the core's ALU/result path and the data memory.

Parameters:
- MEM_LAT, 1, cycles the memory needs per access; legal range 1..15.
- AW, 64, address width.
- DW, 64, data width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- c_req  in  1  core request; held high until c_done.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  AW  core byte address.
- c_wdata  in  DW  core store data.
- c_funct3  in  3  core access size/sign code, passed to memory.
- c_done  out  1  one-cycle completion pulse to core.
- c_rdata  out  DW  core load data; valid while c_done=1, held afterwards.
- d_req, d_we, d_addr, d_wdata, d_funct3  in  same widths  DMA request group, same rules as core.
- d_done  out  1  DMA completion pulse.
- d_rdata  out  DW  DMA load data.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_funct3  out  3  memory access code.
- mem_rdata  in  DW  memory read data.
- stall_core  out  1  combinational: c_req & ~c_done.

Behaviour:
- Reset:
  - FSM returns to IDLE; rr_ptr=0 (core favoured); cnt=0.
  - All registered outputs go to 0: c_done, d_done, c_rdata, d_rdata, mem_addr, mem_wdata, mem_we, mem_re, mem_funct3.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant C if rr_ptr=0, else D.
  - On grant: latch owner, we, addr, wdata, funct3 into registers; cnt<=MEM_LAT-1; go to ACCESS.
- ACCESS:
  - mem_addr, mem_wdata and mem_funct3 come from the latched registers.
  - mem_re = ~we for every ACCESS cycle.
  - mem_we = we in the first ACCESS cycle only, so a store issues exactly one write.
  - While cnt>0: decrement cnt.
  - When cnt==0: if it is a read, capture mem_rdata into the owner's rdata register; go to DONE.
- DONE:
  - Owner's done = 1 for exactly this cycle.
  - rr_ptr <= (owner==C) ? 1 : 0, so the other requester is favoured next.
  - Go to IDLE.
  - A write leaves the owner's rdata unchanged.
- Latency:
  - Grant edge to done pulse = MEM_LAT+1 cycles.
  - Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Handshake:
  - A requester drops req in the cycle after done.
  - A req still high in IDLE after DONE is treated as a new request.
  - Request inputs are ignored outside IDLE, because latched values are used.
- Simultaneous requests under round robin: C and D alternate strictly; no starvation.
- Request arriving during ACCESS/DONE of the other port: it waits. It is guaranteed to win the next IDLE because of rr_ptr.
- Reset mid-operation:
  - The access is aborted and no done pulse is issued.
  - A store whose mem_we cycle has already passed stays committed.
- Memory outputs stay at their last latched values outside ACCESS; only the enables are deasserted.

Optional Feature:
- Macro: DMEM_ARB_CORE_PRIO_EN.
- Defined: fixed priority; C always wins a simultaneous IDLE request; rr_ptr is neither used nor updated.
  - Still required: the DMA request must complete once C is idle for one IDLE cycle.
- Undefined: round-robin as described above.

Test Plan:
- Core store then load, MEM_LAT=1:
  - c_we=1, addr=0x10, wdata=0xDEADBEEF, funct3=3 → mem_we high for exactly one cycle; c_done 2 cycles after grant.
  - Read of 0x10 → c_rdata=0xDEADBEEF with c_done; stall_core high until c_done.
- Simultaneous requests from reset: C and D both request (C addr 0x0, D addr 0x8) → C granted first, D second. Both stay high for 4 transactions → grants alternate C, D, C, D.
- MEM_LAT=3, DMA read of 0x20:
  - mem_re high for 3 cycles; d_done 4 cycles after grant.
  - Core request arriving mid-access → waits, is granted in the next IDLE, stall_core stays high throughout.
- Reset asserted during ACCESS of a core read:
  - All outputs 0 immediately, without waiting for a clock edge; no c_done.
  - After release, a new c_req completes normally.
- DMEM_ARB_CORE_PRIO_EN defined, both requesting continuously: C is granted every transaction. D is granted in the first IDLE after C drops req.
- Write leaves rdata intact: load 0x55 into c_rdata, then store → c_rdata stays 0x55 after the store's c_done.
